// File: rtl/systola_mem_pkg.sv
// Shared types and defaults for the Systola SRAM arbiter.
// The optional post-reset zero-fill is enabled by defining MEM_ARB_CLEAR_EN.
package systola_mem_pkg;

    localparam int WORD_LEN_DEF = 32;
    localparam int ADDR_LEN_DEF = 10;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_arb_state_t;

    typedef struct packed {
        logic                    we;
        logic [ADDR_LEN_DEF-1:0] addr;
        logic [WORD_LEN_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: the first set request after `last`,
// scanning circularly, wins.
module mem_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Define MEM_ARB_CLEAR_EN to zero-fill the whole memory after every reset.
module mem_arbiter
    import systola_mem_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ*WORD_LEN-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WORD_LEN-1:0]          rsp_data,
    output logic                         init_done,
    output logic                         mem_cen,
    output logic                         mem_wen,
    output logic [ADDR_LEN-1:0]          mem_a,
    output logic [WORD_LEN-1:0]          mem_d,
    input  logic [WORD_LEN-1:0]          mem_q
);

    typedef struct packed {
        logic                we;
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] wdata;
    } req_t;

    logic                run;
    logic                clearing;
    logic [ADDR_LEN-1:0] clr_a;
    logic [NUM_REQ-1:0]  req_elig;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                any;
    req_t                sel;

    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ADDR_LEN-1:0] a_q, a_d;
    logic [WORD_LEN-1:0] d_q, d_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

`ifdef MEM_ARB_CLEAR_EN
    mem_arb_state_t      state_q, state_d;
    logic [ADDR_LEN-1:0] clr_addr_q, clr_addr_d;

    // Counter stops at all-ones instead of wrapping; that cycle is the last write.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            if (&clr_addr_q) state_d    = RUN;
            else             clr_addr_d = clr_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign run      = !reset && (state_q == RUN);
    assign clearing = !reset && (state_q == CLEAR);
    assign clr_a    = clr_addr_q;
`else
    assign run      = !reset;
    assign clearing = 1'b0;
    assign clr_a    = '0;
`endif

    assign init_done = run;
    assign req_elig  = req_valid & {NUM_REQ{run}};

    mem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req_elig),
        .last    (last_grant_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        sel.we    = req_we[gnt_idx];
        sel.addr  = req_addr[int'(gnt_idx)*ADDR_LEN +: ADDR_LEN];
        sel.wdata = req_wdata[int'(gnt_idx)*WORD_LEN +: WORD_LEN];
    end

    assign req_ready = gnt;

    // Address/data hold their last driven value while idle.
    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        a_d     = a_q;
        d_d     = d_q;
        if (clearing) begin
            mem_cen = 1'b0;
            mem_wen = 1'b0;
            a_d     = clr_a;
            d_d     = '0;
        end else if (any) begin
            mem_cen = 1'b0;
            mem_wen = ~sel.we;
            a_d     = sel.addr;
            d_d     = sel.wdata;
        end
        if (reset) begin
            a_d = '0;
            d_d = '0;
        end
    end

    assign mem_a = a_d;
    assign mem_d = d_d;

    always_comb begin
        last_grant_d = any ? gnt_idx : last_grant_q;
        rsp_valid_d  = any && !sel.we;
        rsp_id_d     = rsp_valid_d ? gnt_idx : rsp_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            a_q          <= '0;
            d_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            d_q          <= d_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // A response in flight when reset hits is dropped immediately.
    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_id    = reset ? '0 : rsp_id_q;
    assign rsp_data  = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural SRAM model.
// Build with MEM_ARB_CLEAR_EN defined to also exercise the zero-fill sequence.
module tb_mem_arbiter;

    localparam int WL = 32;
    localparam int AL = 10;
    localparam int NR = 2;
    localparam int IW = 1;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_we;
    logic [NR*AL-1:0] req_addr;
    logic [NR*WL-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [WL-1:0]    rsp_data;
    logic             init_done;
    logic             mem_cen, mem_wen;
    logic [AL-1:0]    mem_a;
    logic [WL-1:0]    mem_d;
    logic [WL-1:0]    mem_q;

    mem_arbiter #(.WORD_LEN(WL), .ADDR_LEN(AL), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    logic [WL-1:0] sram [0:(1<<AL)-1];
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_a] <= mem_d;
            else          mem_q       <= sram[mem_a];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            c;
        logic [IW-1:0] id;
        logic [WL-1:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.c));
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AL-1:0] a0, input logic [AL-1:0] a1,
                         input logic [WL-1:0] d0, input logic [WL-1:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // Check the grant at the next negedge; queue the read response if expected.
    task automatic grant_chk(input string nm, input logic [1:0] rdy,
                             input logic [WL-1:0] rdata, input bit push);
        exp_t e;
        int   idx;
        @(negedge clk);
        chk(nm, 64'(req_ready), 64'(rdy));
        idx = rdy[1] ? 1 : 0;
        if (push && rdy != 2'b00 && !req_we[idx]) begin
            e.c    = cyc + 1;
            e.id   = IW'(idx);
            e.data = rdata;
            sb.push_back(e);
        end
    endtask

`ifdef MEM_ARB_CLEAR_EN
    task automatic clear_walk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("clr_write", {mem_cen, mem_wen, mem_a, mem_d, init_done, req_ready},
                {2'b00, AL'(i), 32'h0, 1'b0, 2'b00});
            step();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive(2'b11, 2'b00, 10'd7, 10'd9, 32'h1, 32'h2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_cen_wen", {mem_cen, mem_wen}, 64'b11);
        chk("rst_a_d", {mem_a, mem_d}, 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        step();
        reset = 1'b0;
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);

`ifdef MEM_ARB_CLEAR_EN
        clear_walk(200);
        reset = 1'b1;
        #1;
        chk("midclr_rst_out", {mem_cen, mem_wen, mem_a, mem_d, init_done, req_ready, rsp_valid},
            {2'b11, 10'd0, 32'h0, 1'b0, 2'b00, 1'b0});
        step();
        reset = 1'b0;
        clear_walk(1 << AL);
        @(negedge clk);
        chk("clr_init_done", 64'(init_done), 64'd1);
        drive(2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0);
        grant_chk("clr_rd5", 2'b01, 32'h0, 1'b1);
        step();
`else
        @(negedge clk);
        chk("init_done", 64'(init_done), 64'd1);
        step();
`endif

        // write then immediate read-back by requester 0
        drive(2'b01, 2'b01, 10'd3, 10'd0, 32'hDEADBEEF, 32'h0);
        grant_chk("wr3_grant", 2'b01, 32'h0, 1'b1);
        chk("wr3_mem", {mem_cen, mem_wen, mem_a, mem_d}, {2'b00, 10'd3, 32'hDEADBEEF});
        step();
        drive(2'b01, 2'b00, 10'd3, 10'd0, 32'h0, 32'h0);
        grant_chk("rd3_grant", 2'b01, 32'hDEADBEEF, 1'b1);
        chk("rd3_mem", {mem_cen, mem_wen, mem_a}, {2'b01, 10'd3});
        step();

        drive(2'b01, 2'b01, 10'd10, 10'd0, 32'h1111000A, 32'h0);
        grant_chk("wr10", 2'b01, 32'h0, 1'b1);
        step();
        drive(2'b10, 2'b10, 10'd0, 10'd20, 32'h0, 32'h22220014);
        grant_chk("wr20", 2'b10, 32'h0, 1'b1);
        step();

        drive(2'b00, 2'b00, 10'd1, 10'd2, 32'h5, 32'h6);
        @(negedge clk);
        chk("idle_hold", {mem_cen, mem_wen, mem_a, mem_d}, {2'b11, 10'd20, 32'h22220014});
        step();

        // contention: strict alternation starting at requester 0
        drive(2'b11, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            grant_chk("contend", (k % 2) ? 2'b10 : 2'b01,
                      (k % 2) ? 32'h22220014 : 32'h1111000A, 1'b1);
            step();
        end

        // starvation: requester 0 pulses once against a busy requester 1
        drive(2'b10, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        grant_chk("starve_a", 2'b10, 32'h22220014, 1'b1);
        step();
        drive(2'b11, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        grant_chk("starve_b", 2'b01, 32'h1111000A, 1'b1);
        step();
        drive(2'b10, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        grant_chk("starve_c", 2'b10, 32'h22220014, 1'b1);
        step();

        // reset in the cycle after a read grant drops the response
        drive(2'b01, 2'b00, 10'd3, 10'd0, 32'h0, 32'h0);
        grant_chk("rrst_grant", 2'b01, 32'h0, 1'b0);
        step();
        reset = 1'b1;
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rrst_rsp_id", 64'(rsp_id), 64'd0);
        step();
        reset = 1'b0;

`ifdef MEM_ARB_CLEAR_EN
        clear_walk(1 << AL);
        @(negedge clk);
        chk("reclr_init_done", 64'(init_done), 64'd1);
        drive(2'b11, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        grant_chk("post_rst_grant", 2'b01, 32'h0, 1'b1);
        step();
`else
        drive(2'b11, 2'b00, 10'd10, 10'd20, 32'h0, 32'h0);
        grant_chk("post_rst_grant", 2'b01, 32'h1111000A, 1'b1);
        step();
`endif

        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
